// File: rtl/pong_sound_sequencer.sv
// Pong sound effect sequencer: arbitrates wall/paddle/score requests
// onto one square-wave note generator using a small note ROM.
module pong_sound_sequencer #(
    parameter int NumberOfBits = 20,
    parameter int TickDivide   = 500000,
    parameter int TickBits     = 20
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    WallHit,
    input  logic                    PaddleHit,
    input  logic                    Score,
    output logic [NumberOfBits-1:0] HalfPeriod,
    output logic                    ToneEnable,
    output logic                    Busy,
    output logic [1:0]              Effect
);
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [TickBits-1:0] PrescLast = TickBits'(TickDivide - 1);

    state_t                  state_q;
    logic [2:0]              req_q;
    logic [2:0]              pend_q;
    logic [2:0]              pend_d;
    logic [2:0]              rise;
    logic [2:0]              clr;
    logic [1:0]              effect_q;
    logic [1:0]              note_q;
    logic [1:0]              note_nx;
    logic [1:0]              hi_eff;
    logic [TickBits-1:0]     presc_q;
    logic [3:0]              tick_q;
    logic [NumberOfBits-1:0] half_q;
    logic                    tone_q;
    logic                    busy_q;
    logic                    start;
    logic                    tick_end;
    logic                    note_end;

    function automatic logic [NumberOfBits-1:0] rom_half(
        input logic [1:0] e, input logic [1:0] n);
        logic [16:0] v;
        case ({e, n})
            4'b01_00: v = 17'd95557;
            4'b10_00: v = 17'd63776;
            4'b10_01: v = 17'd47778;
            4'b11_00: v = 17'd95557;
            4'b11_01: v = 17'd85131;
            4'b11_10: v = 17'd75843;
            default:  v = 17'd0;
        endcase
        return NumberOfBits'(v);
    endfunction

    function automatic logic [3:0] rom_dur(
        input logic [1:0] e, input logic [1:0] n);
        logic [3:0] d;
        case ({e, n})
            4'b01_00: d = 4'd5;
            4'b10_00: d = 4'd3;
            4'b10_01: d = 4'd3;
            4'b11_00: d = 4'd10;
            4'b11_01: d = 4'd10;
            4'b11_10: d = 4'd10;
            default:  d = 4'd1;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] rom_len(input logic [1:0] e);
        logic [1:0] l;
        case (e)
            2'd1:    l = 2'd1;
            2'd2:    l = 2'd2;
            2'd3:    l = 2'd3;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    always_comb begin
        rise   = {Score, PaddleHit, WallHit} & ~req_q;
        hi_eff = 2'd0;
        if (pend_q[2]) begin
            hi_eff = 2'd3;
        end else if (pend_q[1]) begin
            hi_eff = 2'd2;
        end else if (pend_q[0]) begin
            hi_eff = 2'd1;
        end
        // effect_q is 0 in IDLE, so this covers both start and preemption
        start    = hi_eff > effect_q;
        clr      = start ? (3'b001 << (hi_eff - 2'd1)) : 3'b000;
        pend_d   = (pend_q & ~clr) | rise;
        tick_end = presc_q == PrescLast;
        note_end = tick_end &&
                   (tick_q == rom_dur(effect_q, note_q) - 4'd1);
        note_nx  = note_q + 2'd1;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            req_q    <= '0;
            pend_q   <= '0;
            effect_q <= '0;
            note_q   <= '0;
            presc_q  <= '0;
            tick_q   <= '0;
            half_q   <= '0;
            tone_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            req_q  <= {Score, PaddleHit, WallHit};
            pend_q <= pend_d;
            if (start) begin
                state_q  <= PLAY;
                effect_q <= hi_eff;
                note_q   <= '0;
                presc_q  <= '0;
                tick_q   <= '0;
                half_q   <= rom_half(hi_eff, 2'd0);
                tone_q   <= 1'b1;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    PLAY: begin
                        presc_q <= tick_end ? '0 : presc_q + 1'b1;
                        if (tick_end) tick_q <= tick_q + 4'd1;
                        if (note_end) begin
                            tick_q <= '0;
                            half_q <= '0;
                            tone_q <= 1'b0;
                            if (note_nx < rom_len(effect_q)) begin
                                state_q <= GAP;
                            end else begin
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                                effect_q <= '0;
                                note_q   <= '0;
                            end
                        end
                    end
                    GAP: begin
                        presc_q <= tick_end ? '0 : presc_q + 1'b1;
                        if (tick_end) begin
                            state_q <= PLAY;
                            note_q  <= note_nx;
                            half_q  <= rom_half(effect_q, note_nx);
                            tone_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign HalfPeriod = half_q;
    assign ToneEnable = tone_q;
    assign Busy       = busy_q;
    assign Effect     = effect_q;
endmodule

// File: tb/tb_pong_sound_sequencer.sv
// Bench for pong_sound_sequencer: elapsed-time reference model compared
// every cycle, plus literal timing/count expectations per scenario.
module tb_pong_sound_sequencer;
    localparam int TD = 4;
    localparam int NB = 20;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          WallHit = 1'b0;
    logic          PaddleHit = 1'b0;
    logic          Score = 1'b0;
    logic [NB-1:0] HalfPeriod;
    logic          ToneEnable;
    logic          Busy;
    logic [1:0]    Effect;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pong_sound_sequencer #(
        .NumberOfBits(NB),
        .TickDivide  (TD),
        .TickBits    (8)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .WallHit   (WallHit),
        .PaddleHit (PaddleHit),
        .Score     (Score),
        .HalfPeriod(HalfPeriod),
        .ToneEnable(ToneEnable),
        .Busy      (Busy),
        .Effect    (Effect)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic int note_cnt(int e);
        case (e)
            1: return 1;
            2: return 2;
            3: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int note_dur(int e, int i);
        case (e)
            1: return 5;
            2: return 3;
            3: return 10;
            default: return 0;
        endcase
    endfunction

    function automatic int note_half(int e, int i);
        case (e)
            1: return 95557;
            2: return (i == 0) ? 63776 : 47778;
            3: return (i == 0) ? 95557 : (i == 1) ? 85131 : 75843;
            default: return 0;
        endcase
    endfunction

    function automatic int seq_len(int e);
        int t = 0;
        for (int i = 0; i < note_cnt(e); i++) t += note_dur(e, i) * TD;
        return t + (note_cnt(e) - 1) * TD;
    endfunction

    // Reference: current effect plus cycles elapsed since it started
    int            m_eff = 0;
    int            m_el = 0;
    logic [2:0]    m_pend = '0;
    logic [2:0]    m_prev = '0;
    logic [NB-1:0] e_half = '0;
    logic          e_tone = 1'b0;
    logic          e_busy = 1'b0;
    logic [1:0]    e_eff = '0;

    always @(posedge Clock or negedge Reset) begin : model
        int hi;
        int r;
        bit found;
        logic [2:0] ins;
        logic [2:0] rise;
        if (!Reset) begin
            m_eff = 0;
            m_el = 0;
            m_pend = '0;
            m_prev = '0;
        end else begin
            ins = {Score, PaddleHit, WallHit};
            rise = ins & ~m_prev;
            hi = m_pend[2] ? 3 : m_pend[1] ? 2 : m_pend[0] ? 1 : 0;
            if (hi > m_eff) begin
                m_eff = hi;
                m_el = 0;
                m_pend[hi-1] = 1'b0;
            end else if (m_eff != 0) begin
                m_el++;
                if (m_el >= seq_len(m_eff)) begin
                    m_eff = 0;
                    m_el = 0;
                end
            end
            m_pend = m_pend | rise;
            m_prev = ins;
        end
        e_half = '0;
        e_tone = 1'b0;
        e_busy = (m_eff != 0);
        e_eff = 2'(m_eff);
        if (m_eff != 0) begin
            r = m_el;
            found = 1'b0;
            for (int i = 0; i < note_cnt(m_eff); i++) begin
                if (!found) begin
                    if (r < note_dur(m_eff, i) * TD) begin
                        e_half = NB'(note_half(m_eff, i));
                        e_tone = 1'b1;
                        found = 1'b1;
                    end else begin
                        r -= note_dur(m_eff, i) * TD;
                        if (r < TD) found = 1'b1;
                        else r -= TD;
                    end
                end
            end
        end
    end

    int   n63776, n47778, n95557, n_gap, n_busy, n_busy3, first_tone;
    int   first_b[4];
    int   last_b[4];
    int   order[$];
    logic prev_busy = 1'b0;
    logic [1:0] prev_eff = '0;

    always @(negedge Clock) begin
        if (Reset) begin
            checks++;
            if (HalfPeriod !== e_half || ToneEnable !== e_tone ||
                Busy !== e_busy || Effect !== e_eff) begin
                errors++;
                $display("FAIL model cyc=%0d got h=%0d t=%b b=%b e=%0d want h=%0d t=%b b=%b e=%0d",
                         cyc, HalfPeriod, ToneEnable, Busy, Effect,
                         e_half, e_tone, e_busy, e_eff);
            end
            if (ToneEnable && first_tone < 0) first_tone = cyc;
            if (ToneEnable && HalfPeriod == 63776) n63776++;
            if (ToneEnable && HalfPeriod == 47778) n47778++;
            if (ToneEnable && HalfPeriod == 95557) n95557++;
            if (Busy && !ToneEnable) n_gap++;
            if (Busy) begin
                n_busy++;
                if (Effect == 2'd3) n_busy3++;
                if (first_b[Effect] < 0) first_b[Effect] = cyc;
                last_b[Effect] = cyc;
                if (!prev_busy || Effect != prev_eff) order.push_back(int'(Effect));
            end
            prev_busy = Busy;
            prev_eff = Effect;
        end else begin
            prev_busy = 1'b0;
            prev_eff = '0;
        end
    end

    task automatic clear_stats();
        n63776 = 0;
        n47778 = 0;
        n95557 = 0;
        n_gap = 0;
        n_busy = 0;
        n_busy3 = 0;
        first_tone = -1;
        for (int i = 0; i < 4; i++) begin
            first_b[i] = -1;
            last_b[i] = -1;
        end
        order.delete();
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge Clock);
    endtask

    int pulse_cyc;

    task automatic pulse(int which);
        @(negedge Clock);
        case (which)
            0: WallHit = 1'b1;
            1: PaddleHit = 1'b1;
            default: Score = 1'b1;
        endcase
        pulse_cyc = cyc;
        @(negedge Clock);
        WallHit = 1'b0;
        PaddleHit = 1'b0;
        Score = 1'b0;
    endtask

    task automatic wait_half(string name, int v, int lim);
        int k = 0;
        while (HalfPeriod !== NB'(v) && k < lim) begin
            @(negedge Clock);
            k++;
        end
        checks++;
        if (k >= lim) begin
            errors++;
            $display("FAIL %s timeout got %0d want %0d", name, HalfPeriod, v);
        end
    endtask

    function automatic int ord(int i);
        return (order.size() > i) ? order[i] : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        clear_stats();
        tick(3);
        check("reset_half", int'(HalfPeriod), 0);
        check("reset_tone", int'(ToneEnable), 0);
        check("reset_busy", int'(Busy), 0);
        check("reset_eff", int'(Effect), 0);
        Reset = 1'b1;
        tick(2);

        clear_stats();
        pulse(0);
        tick(40);
        check("wall_tone", n95557, 20);
        check("wall_delay", first_tone - pulse_cyc, 2);
        check("wall_gap", n_gap, 0);
        check("wall_cnt", order.size(), 1);
        check("wall_eff", ord(0), 1);
        check("wall_idle", int'(Busy), 0);

        clear_stats();
        pulse(1);
        tick(45);
        check("pad_n1", n63776, 12);
        check("pad_gap", n_gap, 4);
        check("pad_n2", n47778, 12);
        check("pad_busy", n_busy, 28);

        clear_stats();
        pulse(1);
        wait_half("pre_wait", 63776, 10);
        tick(5);
        pulse(2);
        tick(160);
        check("pre_score", n_busy3, 128);
        check("pre_cnt", order.size(), 2);
        check("pre_o0", ord(0), 2);
        check("pre_o1", ord(1), 3);
        check("pre_nores", n47778, 0);
        check("pre_idle", int'(Busy), 0);

        clear_stats();
        pulse(2);
        wait_half("q_wait", 95557, 10);
        tick(10);
        pulse(0);
        tick(180);
        check("q_o0", ord(0), 3);
        check("q_o1", ord(1), 1);
        check("q_idlegap", first_b[1] - last_b[3], 2);
        check("q_busy", n_busy, 148);

        clear_stats();
        pulse(0);
        tick(19);
        pulse(0);
        tick(40);
        check("edge_tone", n95557, 40);
        check("edge_cnt", order.size(), 2);

        clear_stats();
        @(negedge Clock);
        WallHit = 1'b1;
        PaddleHit = 1'b1;
        Score = 1'b1;
        tick(200);
        WallHit = 1'b0;
        PaddleHit = 1'b0;
        Score = 1'b0;
        tick(20);
        check("sim_cnt", order.size(), 3);
        check("sim_o0", ord(0), 3);
        check("sim_o1", ord(1), 2);
        check("sim_o2", ord(2), 1);
        check("sim_gap32", first_b[2] - last_b[3], 2);
        check("sim_gap21", first_b[1] - last_b[2], 2);
        check("sim_busy", n_busy, 176);
        check("sim_idle", int'(Busy), 0);

        clear_stats();
        pulse(2);
        wait_half("rst_wait", 75843, 120);
        @(posedge Clock);
        #1 Reset = 1'b0;
        #1;
        check("rst_half", int'(HalfPeriod), 0);
        check("rst_tone", int'(ToneEnable), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_eff", int'(Effect), 0);
        tick(2);
        Reset = 1'b1;
        clear_stats();
        tick(30);
        check("rst_quiet", n_busy, 0);

        repeat (3000) begin
            @(negedge Clock);
            if ($urandom_range(0, 40) == 0) WallHit = ~WallHit;
            if ($urandom_range(0, 60) == 0) PaddleHit = ~PaddleHit;
            if ($urandom_range(0, 90) == 0) Score = ~Score;
        end
        WallHit = 1'b0;
        PaddleHit = 1'b0;
        Score = 1'b0;
        tick(600);
        check("rand_idle", int'(Busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
